// File: rtl/receptor_serial_paridade_pkg.sv
// Shared definitions for the serial frame receiver: FSM state codes and the
// default frame geometry used by the receiver and its benches.
package receptor_serial_paridade_pkg;

  localparam int LARGURA_PADRAO = 6;
  localparam int DIV_PADRAO     = 4;

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    INICIO = 3'd1,
    DADOS  = 3'd2,
    PARADA = 3'd3,
    ESPERA = 3'd4
  } estado_t;

endpackage

// File: rtl/receptor_serial_paridade_sincronizador_2ff.sv
// Two-flop synchroniser for an idle-high asynchronous line; both stages reset
// to 1 so a reset never looks like a start bit.
module sincronizador_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_d, s1_q;
  logic s2_d, s2_q;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/receptor_serial_paridade.sv
// Serial frame receiver: start(0), LARGURA bits LSB-first, stop(1). Delivers the
// raw word (data + parity) with a one-cycle strobe; parity is checked downstream.
module receptor_serial_paridade
  import receptor_serial_paridade_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO,
  parameter int DIV     = DIV_PADRAO
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic [LARGURA-1:0] palavra,
  output logic               palavra_valida,
  output logic               erro_quadro,
  output logic               ocupado
);

  localparam int CW = $clog2(DIV);
  localparam int NW = $clog2(LARGURA + 1);

  localparam logic [CW-1:0] CNT_MEIO  = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_FIM   = CW'(DIV - 1);
  localparam logic [NW-1:0] NBITS_ULT = NW'(LARGURA - 1);

  logic rx_s;

  estado_t            estado_d, estado_q;
  logic [CW-1:0]      cnt_d, cnt_q;
  logic [NW-1:0]      nbits_d, nbits_q;
  logic [LARGURA-1:0] shift_d, shift_q;
  logic [LARGURA-1:0] palavra_d, palavra_q;
  logic               valida_d, valida_q;
  logic               erro_d, erro_q;
  logic               ocupado_d, ocupado_q;

  sincronizador_2ff u_sincronizador (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    nbits_d   = nbits_q;
    shift_d   = shift_q;
    palavra_d = palavra_q;
    valida_d  = 1'b0;
    erro_d    = 1'b0;

    case (estado_q)
      OCIOSO: begin
        if (!rx_s) begin
          estado_d = INICIO;
          cnt_d    = '0;
        end
      end

      // A start bit that is gone by its midpoint is treated as a glitch.
      INICIO: begin
        if (cnt_q == CNT_MEIO) begin
          cnt_d = '0;
          if (!rx_s) begin
            estado_d = DADOS;
            nbits_d  = '0;
          end else begin
            estado_d = OCIOSO;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DADOS: begin
        if (cnt_q == CNT_FIM) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[LARGURA-1:1]};
          nbits_d = nbits_q + NW'(1);
          if (nbits_q == NBITS_ULT) begin
            estado_d = PARADA;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // Leaving mid stop bit lets a back-to-back start edge be caught in OCIOSO.
      PARADA: begin
        if (cnt_q == CNT_FIM) begin
          cnt_d = '0;
          if (rx_s) begin
            palavra_d = shift_q;
            valida_d  = 1'b1;
            estado_d  = OCIOSO;
          end else begin
            erro_d   = 1'b1;
            estado_d = ESPERA;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ESPERA: begin
        if (rx_s) begin
          estado_d = OCIOSO;
        end
      end

      default: begin
        estado_d = OCIOSO;
      end
    endcase

    ocupado_d = (estado_d != OCIOSO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q  <= OCIOSO;
      cnt_q     <= '0;
      nbits_q   <= '0;
      shift_q   <= '0;
      palavra_q <= '0;
      valida_q  <= 1'b0;
      erro_q    <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      nbits_q   <= nbits_d;
      shift_q   <= shift_d;
      palavra_q <= palavra_d;
      valida_q  <= valida_d;
      erro_q    <= erro_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign palavra        = palavra_q;
  assign palavra_valida = valida_q;
  assign erro_quadro    = erro_q;
  assign ocupado        = ocupado_q;

endmodule

// File: tb/tb_receptor_serial_paridade.sv
// Bench for receptor_serial_paridade: an event-queue model predicts every strobe
// from the frames sent, and a per-cycle compare process checks the DUT against it.
module tb_receptor_serial_paridade;

  localparam int LARGURA  = 6;
  localparam int DIV      = 4;
  localparam int LATENCIA = 2 + DIV / 2 + (LARGURA + 1) * DIV;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               rx  = 1'b1;
  logic [LARGURA-1:0] palavra;
  logic               palavra_valida;
  logic               erro_quadro;
  logic               ocupado;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int n_valida     = 0;
  int n_erro       = 0;
  int ultimo_valida     = 0;
  int penultimo_valida  = 0;
  logic rst_smp = 1'b1;

  typedef struct {
    int                 quando;
    bit                 erro;
    logic [LARGURA-1:0] palavra;
  } evento_t;

  evento_t            eventos[$];
  logic [LARGURA-1:0] palavra_esperada = '0;

  receptor_serial_paridade #(
    .LARGURA (LARGURA),
    .DIV     (DIV)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx             (rx),
    .palavra        (palavra),
    .palavra_valida (palavra_valida),
    .erro_quadro    (erro_quadro),
    .ocupado        (ocupado)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rst_smp <= rst;
  end

  task automatic checkOutput(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    tests_run++;
    if (atual !== esperado) begin
      tests_failed++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", nome, cyc, atual, esperado);
    end
  endtask

  // Drives one frame starting at the current negedge; returns k, the edge that
  // registers the start bit. A nonzero abort_at stops after that many cycles.
  task automatic applyStimulus(input logic [LARGURA-1:0] w, input logic stop,
                               input int abort_at, output int k);
    logic [LARGURA+1:0] bits;
    int n;
    bits = {stop, w, 1'b0};
    k = cyc + 1;
    n = 0;
    if (abort_at == 0) begin
      eventos.push_back('{quando: k + LATENCIA, erro: !stop, palavra: w});
    end
    for (int b = 0; b < LARGURA + 2; b++) begin
      rx = bits[b];
      for (int c = 0; c < DIV; c++) begin
        if (abort_at > 0 && n == abort_at) return;
        @(negedge clk);
        n++;
      end
    end
  endtask

  always @(negedge clk) begin
    logic exp_v;
    logic exp_e;
    exp_v = 1'b0;
    exp_e = 1'b0;
    if (rst_smp) begin
      eventos.delete();
      palavra_esperada = '0;
      checkOutput("ocupado_in_reset", ocupado, 0);
    end else if (eventos.size() > 0 && eventos[0].quando == cyc) begin
      if (eventos[0].erro) begin
        exp_e = 1'b1;
      end else begin
        exp_v = 1'b1;
        palavra_esperada = eventos[0].palavra;
      end
      void'(eventos.pop_front());
    end
    checkOutput("palavra_valida", palavra_valida, exp_v);
    checkOutput("erro_quadro", erro_quadro, exp_e);
    checkOutput("palavra", palavra, palavra_esperada);
    if (palavra_valida === 1'b1) begin
      n_valida++;
      penultimo_valida = ultimo_valida;
      ultimo_valida    = cyc;
    end
    if (erro_quadro === 1'b1) n_erro++;
  end

  initial begin
    int k;
    int k2;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_palavra", palavra, 0);
    checkOutput("reset_ocupado", ocupado, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Test 1: good frame, strobe exactly 32 edges after k
    applyStimulus(6'b101101, 1'b1, 0, k);
    checkOutput("t1_no_strobe_at_k31", palavra_valida, 0);
    @(negedge clk);
    checkOutput("t1_strobe_at_k32", palavra_valida, 1);
    checkOutput("t1_palavra_literal", palavra, 6'b101101);
    @(negedge clk);
    checkOutput("t1_strobe_one_cycle", palavra_valida, 0);
    repeat (4) @(negedge clk);

    // Test 2: one-cycle low glitch is rejected
    rx = 1'b0;
    k = cyc + 1;
    @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("t2_ocupado_at_k2", ocupado, 1);
    repeat (2) @(negedge clk);
    checkOutput("t2_ocupado_at_k4", ocupado, 0);
    repeat (6) @(negedge clk);

    // Test 3: bad stop bit
    applyStimulus(6'b010011, 1'b0, 0, k);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("t3_palavra_kept", palavra, 6'b101101);
    checkOutput("t3_n_erro", n_erro, 1);

    // Test 4: break yields one error, then a normal frame
    rx = 1'b0;
    k = cyc + 1;
    eventos.push_back('{quando: k + LATENCIA, erro: 1'b1, palavra: 6'b000000});
    repeat (200) @(negedge clk);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("t4_n_erro", n_erro, 2);
    checkOutput("t4_n_valida", n_valida, 1);
    applyStimulus(6'b000111, 1'b1, 0, k);
    repeat (4) @(negedge clk);
    checkOutput("t4_palavra_literal", palavra, 6'b000111);

    // Test 5: reset in the middle of data bit 3
    applyStimulus(6'b110010, 1'b1, 18, k);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    checkOutput("t5_palavra_zero", palavra, 0);
    checkOutput("t5_valida_zero", palavra_valida, 0);
    checkOutput("t5_erro_zero", erro_quadro, 0);
    checkOutput("t5_ocupado_zero", ocupado, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    applyStimulus(6'b111111, 1'b1, 0, k);
    repeat (4) @(negedge clk);
    checkOutput("t5_palavra_literal", palavra, 6'b111111);

    // Test 6: back-to-back frames
    applyStimulus(6'b100001, 1'b1, 0, k);
    applyStimulus(6'b011110, 1'b1, 0, k2);
    repeat (4) @(negedge clk);
    checkOutput("t6_palavra_literal", palavra, 6'b011110);
    checkOutput("t6_strobe_spacing", ultimo_valida - penultimo_valida, 32);

    repeat (10) @(negedge clk);
    checkOutput("total_valida", n_valida, 5);
    checkOutput("total_erro", n_erro, 2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
